// File: rtl/rv_core_exec.sv
// Single-cycle RV32I execution slice: PC register, main decoder and ALU.
// Handles R-type and I-type ALU operations plus beq/bne branches.
module rv_core_exec #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr,
   input  logic [DATA_WIDTH-1:0] rd1,
   input  logic [DATA_WIDTH-1:0] rd2,
   input  logic [DATA_WIDTH-1:0] imm_op,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] alu_out,
   output logic                  eq,
   output logic                  reg_write,
   output logic [1:0]            imm_src,
   output logic                  alu_src,
   output logic [2:0]            alu_ctrl,
   output logic                  pc_src
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic                  funct7_5;
   logic [DATA_WIDTH-1:0] op2;
   logic [DATA_WIDTH-1:0] pc_reg;
   logic [DATA_WIDTH-1:0] pc_next;
   logic                  unused_instr_bits;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7_5 = instr[30];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // Main decoder; the branch decision needs eq, so it shares the same process.
   always_comb begin
      reg_write = 1'b0;
      alu_src   = 1'b0;
      imm_src   = 2'b00;
      alu_ctrl  = ALU_ADD;
      pc_src    = 1'b0;
      case (opcode)
         OP_R: begin
            reg_write = 1'b1;
            case (funct3)
               3'b000:  alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
               3'b111:  alu_ctrl = ALU_AND;
               3'b110:  alu_ctrl = ALU_OR;
               3'b010:  alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         OP_I_ALU: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            case (funct3)
               3'b111:  alu_ctrl = ALU_AND;
               3'b110:  alu_ctrl = ALU_OR;
               3'b010:  alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         OP_BRANCH: begin
            imm_src  = 2'b01;
            alu_ctrl = ALU_SUB;
            case (funct3)
               3'b000:  pc_src = eq;
               3'b001:  pc_src = ~eq;
               default: pc_src = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   assign op2 = alu_src ? imm_op : rd2;
   assign eq  = (rd1 == op2);

   always_comb begin
      alu_out = '0;
      case (alu_ctrl)
         ALU_ADD: alu_out = rd1 + op2;
         ALU_SUB: alu_out = rd1 - op2;
         ALU_AND: alu_out = rd1 & op2;
         ALU_OR:  alu_out = rd1 | op2;
         ALU_SLT: alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(rd1) < $signed(op2))};
         default: alu_out = '0;
      endcase
   end

   // Branch targets are PC-relative; both paths wrap modulo 2^DATA_WIDTH.
   assign pc_next = pc_reg + (pc_src ? imm_op : DATA_WIDTH'(4));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_reg <= '0;
      else      pc_reg <= pc_next;
   end

   assign pc_out = pc_reg;

endmodule

// File: tb/tb_rv_core_exec.sv
// Directed bench for rv_core_exec: a mnemonic-level reference model is checked
// every cycle, alongside hand-computed expectations for each scenario.
module tb_rv_core_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr, rd1, rd2, imm_op;
   logic [31:0] pc_out, alu_out;
   logic        eq, reg_write, alu_src, pc_src;
   logic [1:0]  imm_src;
   logic [2:0]  alu_ctrl;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   rv_core_exec #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .rd1(rd1), .rd2(rd2), .imm_op(imm_op),
      .pc_out(pc_out), .alu_out(alu_out), .eq(eq), .reg_write(reg_write),
      .imm_src(imm_src), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .pc_src(pc_src)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] alu;
      logic        eq;
      logic        rw;
      logic [1:0]  isrc;
      logic        asrc;
      logic [2:0]  actl;
      logic        psrc;
   } exp_t;

   // Reference: name the operation, then evaluate it arithmetically.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] m);
      exp_t        e;
      logic [31:0] o2;
      string       mn;
      e  = '0;
      o2 = b;
      mn = "add";
      if (ins[6:0] == 7'h33) begin
         e.rw = 1'b1;
         if (ins[14:12] == 3'd0)      mn = ins[30] ? "sub" : "add";
         else if (ins[14:12] == 3'd7) mn = "and";
         else if (ins[14:12] == 3'd6) mn = "or";
         else if (ins[14:12] == 3'd2) mn = "slt";
      end else if (ins[6:0] == 7'h13) begin
         e.rw   = 1'b1;
         e.asrc = 1'b1;
         o2     = m;
         if (ins[14:12] == 3'd7)      mn = "and";
         else if (ins[14:12] == 3'd6) mn = "or";
         else if (ins[14:12] == 3'd2) mn = "slt";
      end else if (ins[6:0] == 7'h63) begin
         e.isrc = 2'b01;
         mn     = "sub";
      end
      if (mn == "add")      begin e.alu = a + o2; e.actl = 3'd0; end
      else if (mn == "sub") begin e.alu = a - o2; e.actl = 3'd1; end
      else if (mn == "and") begin e.alu = a & o2; e.actl = 3'd2; end
      else if (mn == "or")  begin e.alu = a | o2; e.actl = 3'd3; end
      else                  begin e.alu = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0; e.actl = 3'd5; end
      e.eq = (a == o2);
      if (ins[6:0] == 7'h63)
         e.psrc = (ins[14:12] == 3'd0) ? e.eq : (ins[14:12] == 3'd1) ? !e.eq : 1'b0;
      return e;
   endfunction

   exp_t        exp_now;
   logic [31:0] pc_m;

   always_comb exp_now = model(instr, rd1, rd2, imm_op);

   always @(posedge clk or negedge rst) begin
      if (!rst) pc_m <= 32'd0;
      else      pc_m <= pc_m + (exp_now.psrc ? imm_op : 32'd4);
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_pc",       pc_out,           pc_m);
         cmp("m_alu_out",  alu_out,          exp_now.alu);
         cmp("m_eq",       32'(eq),          32'(exp_now.eq));
         cmp("m_reg_write",32'(reg_write),   32'(exp_now.rw));
         cmp("m_imm_src",  32'(imm_src),     32'(exp_now.isrc));
         cmp("m_alu_src",  32'(alu_src),     32'(exp_now.asrc));
         cmp("m_alu_ctrl", 32'(alu_ctrl),    32'(exp_now.actl));
         cmp("m_pc_src",   32'(pc_src),      32'(exp_now.psrc));
         $display("cycle t=%0t instr=%h rd1=%h rd2=%h imm=%h pc=%h alu=%h",
                  $time, instr, rd1, rd2, imm_op, pc_out, alu_out);
      end
   end

   task automatic drive(input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] m);
      instr = i; rd1 = a; rd2 = b; imm_op = m;
      #1;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #2;
   endtask

   localparam logic [31:0] BNE = 32'hFE209CE3;
   localparam logic [31:0] BEQ = 32'h00000063;

   logic [31:0] vec [8][4];

   initial begin
      rst = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      chk_en = 1'b1;
      cmp("rst_pc", pc_out, 32'h0);
      next_edge();
      next_edge();
      cmp("rst_hold_pc", pc_out, 32'h0);
      rst = 1'b1;

      for (int k = 1; k <= 3; k++) begin
         next_edge();
         cmp("fetch_pc", pc_out, 32'(4 * k));
         cmp("fetch_reg_write", 32'(reg_write), 32'h0);
         cmp("fetch_pc_src", 32'(pc_src), 32'h0);
      end

      drive(BNE, 32'd1, 32'd2, 32'hFFFFFFF8);
      cmp("bne_eq", 32'(eq), 32'h0);
      cmp("bne_pc_src", 32'(pc_src), 32'h1);
      cmp("bne_imm_src", 32'(imm_src), 32'h1);
      cmp("bne_reg_write", 32'(reg_write), 32'h0);
      next_edge();
      cmp("bne_taken_pc", pc_out, 32'h4);
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      next_edge();
      next_edge();
      cmp("refetch_pc", pc_out, 32'hC);
      drive(BNE, 32'd2, 32'd2, 32'hFFFFFFF8);
      cmp("bne_nt_eq", 32'(eq), 32'h1);
      cmp("bne_nt_pc_src", 32'(pc_src), 32'h0);
      cmp("bne_nt_reg_write", 32'(reg_write), 32'h0);
      next_edge();
      cmp("bne_nt_pc", pc_out, 32'h10);

      drive(BEQ, 32'd5, 32'd5, 32'hFFFFFFE0);
      cmp("beq_pc_src", 32'(pc_src), 32'h1);
      next_edge();
      cmp("beq_back_pc", pc_out, 32'hFFFFFFF0);
      drive(BEQ, 32'd5, 32'd5, 32'h00000020);
      next_edge();
      cmp("beq_wrap_pc", pc_out, 32'h10);

      drive(32'h00500093, 32'd0, 32'd0, 32'd5);
      cmp("addi_alu", alu_out, 32'd5);
      cmp("addi_reg_write", 32'(reg_write), 32'h1);
      cmp("addi_alu_src", 32'(alu_src), 32'h1);
      cmp("addi_imm_src", 32'(imm_src), 32'h0);
      cmp("addi_alu_ctrl", 32'(alu_ctrl), 32'h0);
      cmp("addi_pc_src", 32'(pc_src), 32'h0);
      next_edge();

      drive(32'h002081B3, 32'd7, 32'd3, 32'd99);
      cmp("add_alu", alu_out, 32'd10);
      cmp("add_alu_src", 32'(alu_src), 32'h0);
      next_edge();
      drive(32'h402081B3, 32'd7, 32'd3, 32'd99);
      cmp("sub_alu_ctrl", 32'(alu_ctrl), 32'h1);
      cmp("sub_alu", alu_out, 32'd4);
      next_edge();
      drive(32'h402081B3, 32'd0, 32'd1, 32'd0);
      cmp("sub_wrap", alu_out, 32'hFFFFFFFF);
      next_edge();

      drive(32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 32'd0);
      cmp("slt_neg", alu_out, 32'd1);
      next_edge();
      drive(32'h0020A1B3, 32'd1, 32'hFFFFFFFF, 32'd0);
      cmp("slt_swap", alu_out, 32'd0);
      next_edge();
      drive(32'h0020F1B3, 32'h0000F0F0, 32'h0000FF00, 32'd0);
      cmp("and_alu", alu_out, 32'h0000F000);
      next_edge();
      drive(32'h0020E1B3, 32'h0000F0F0, 32'h0000FF00, 32'd0);
      cmp("or_alu", alu_out, 32'h0000FFF0);
      next_edge();

      // Model-only vectors: unsupported opcode/funct3 corners and I-type logic ops.
      vec[0] = '{32'h000000B7, 32'd3,        32'd4,        32'd9};
      vec[1] = '{32'h0020A063, 32'd6,        32'd6,        32'd64};
      vec[2] = '{32'h0FF0F093, 32'h1234,     32'd0,        32'h00FF};
      vec[3] = '{32'h0F00E093, 32'h000F,     32'd0,        32'h00F0};
      vec[4] = '{32'hFFF0A093, 32'h80000000, 32'd0,        32'hFFFFFFFF};
      vec[5] = '{32'h00208063, 32'd8,        32'd8,        32'd8};
      vec[6] = '{32'h002091B3, 32'd10,       32'd20,       32'd0};
      vec[7] = '{32'h4000C093, 32'd5,        32'd0,        32'd6};
      for (int v = 0; v < 8; v++) begin
         drive(vec[v][0], vec[v][1], vec[v][2], vec[v][3]);
         next_edge();
      end

      rst = 1'b0;
      #2;
      rst = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      repeat (8) @(posedge clk);
      #2;
      cmp("pre_arst_pc", pc_out, 32'h20);
      rst = 1'b0;
      #1;
      cmp("arst_pc", pc_out, 32'h0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      next_edge();
      cmp("arst_release_pc", pc_out, 32'h4);
      next_edge();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
